// File: rtl/aes_sbox_arbiter_if.sv
// Signal bundle between the encipher/key-expansion requesters, the shared S-box and aes_sbox_arbiter.
// The slave modport is the arbiter side; master is the requester and S-box side.
interface aes_sbox_arbiter_if;
   logic        enc_req;
   logic [31:0] enc_word;
   logic        enc_grant;
   logic [31:0] enc_new_word;
   logic        enc_valid;

   logic        key_req;
   logic [31:0] key_word;
   logic        key_grant;
   logic [31:0] key_new_word;
   logic        key_valid;

   logic [31:0] sboxw;
   logic [31:0] new_sboxw;
   logic        busy;

   modport slave (
      input  enc_req, enc_word, key_req, key_word, new_sboxw,
      output enc_grant, enc_new_word, enc_valid,
             key_grant, key_new_word, key_valid,
             sboxw, busy
   );

   modport master (
      output enc_req, enc_word, key_req, key_word, new_sboxw,
      input  enc_grant, enc_new_word, enc_valid,
             key_grant, key_new_word, key_valid,
             sboxw, busy
   );
endinterface

// File: rtl/aes_sbox_arbiter.sv
// Shares one combinational AES S-box between the encipher round and key expansion.
// Define AES_SBOX_ARB_RR_EN for round-robin with a MAX_BURST limit; default is fixed key priority.
module aes_sbox_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   aes_sbox_arbiter_if.slave arb
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GNT_ENC = 2'd1;
   localparam logic [1:0] GNT_KEY = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [1:0]  tie_state;
   logic        burst_done;
   logic        enc_fire, key_fire;
   logic        enc_valid_q, key_valid_q;
   logic [31:0] enc_new_word_q, key_new_word_q;

   assign enc_fire = (state_q == GNT_ENC) && arb.enc_req;
   assign key_fire = (state_q == GNT_KEY) && arb.key_req;

`ifdef AES_SBOX_ARB_RR_EN
   localparam logic [3:0] BURST_MAX  = 4'(MAX_BURST);
   localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
   localparam logic       LAST_ENC   = 1'b0;
   localparam logic       LAST_KEY   = 1'b1;

   logic [3:0] burst_cnt_q, burst_cnt_d;
   logic       last_served_q, last_served_d;

   assign tie_state  = (last_served_q == LAST_KEY) ? GNT_ENC : GNT_KEY;
   // >= so an owner that saturated while alone still yields as soon as the rival shows up.
   assign burst_done = (burst_cnt_q >= BURST_LAST);

   always_comb begin
      burst_cnt_d   = burst_cnt_q;
      last_served_d = last_served_q;
      if (state_d != state_q) begin
         burst_cnt_d = '0;
         if (state_d == GNT_ENC)      last_served_d = LAST_ENC;
         else if (state_d == GNT_KEY) last_served_d = LAST_KEY;
      end else if ((enc_fire || key_fire) && (burst_cnt_q < BURST_MAX)) begin
         burst_cnt_d = burst_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         burst_cnt_q   <= '0;
         last_served_q <= LAST_KEY;
      end else begin
         burst_cnt_q   <= burst_cnt_d;
         last_served_q <= last_served_d;
      end
   end
`else
   logic [3:0] unused_max_burst;

   // Fixed priority: key wins ties and a running burst is never cut short.
   assign unused_max_burst = 4'(MAX_BURST);
   assign tie_state        = GNT_KEY;
   assign burst_done       = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (arb.enc_req && arb.key_req) state_d = tie_state;
            else if (arb.enc_req)           state_d = GNT_ENC;
            else if (arb.key_req)           state_d = GNT_KEY;
         end
         GNT_ENC: begin
            if (!arb.enc_req || (arb.key_req && burst_done))
               state_d = arb.key_req ? GNT_KEY : IDLE;
         end
         GNT_KEY: begin
            if (!arb.key_req || (arb.enc_req && burst_done))
               state_d = arb.enc_req ? GNT_ENC : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         enc_valid_q    <= 1'b0;
         key_valid_q    <= 1'b0;
         enc_new_word_q <= 32'h0;
         key_new_word_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         enc_valid_q <= enc_fire;
         key_valid_q <= key_fire;
         if (enc_fire) enc_new_word_q <= arb.new_sboxw;
         if (key_fire) key_new_word_q <= arb.new_sboxw;
      end
   end

   assign arb.enc_grant    = (state_q == GNT_ENC);
   assign arb.key_grant    = (state_q == GNT_KEY);
   assign arb.busy         = (state_q != IDLE);
   assign arb.sboxw        = enc_fire ? arb.enc_word :
                             key_fire ? arb.key_word : 32'h0;
   assign arb.enc_valid    = enc_valid_q;
   assign arb.key_valid    = key_valid_q;
   assign arb.enc_new_word = enc_new_word_q;
   assign arb.key_new_word = key_new_word_q;

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Self-checking bench for aes_sbox_arbiter against a cycle-level ownership model with a real AES S-box.
// Follows the arbitration mode selected by AES_SBOX_ARB_RR_EN.
module tb_aes_sbox_arbiter;

   localparam int MAX_BURST = 4;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   typedef enum int {OWN_NONE, OWN_ENC, OWN_KEY} owner_e;

   logic clk;
   logic reset;

   aes_sbox_arbiter_if bus();

   aes_sbox_arbiter #(.MAX_BURST(MAX_BURST)) dut (
      .clk   (clk),
      .reset (reset),
      .arb   (bus)
   );

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   assign bus.new_sboxw = sub_word(bus.sboxw);

   int checks = 0;
   int errors = 0;

   // Model: who owns the S-box, how many cycles it has held it, who entered a grant last.
   owner_e      m_owner, m_last;
   int          m_held;
   logic        m_enc_v, m_key_v;
   logic [31:0] m_enc_nw, m_key_nw;

   logic        exp_enc_grant, exp_key_grant, exp_busy, exp_enc_valid, exp_key_valid;
   logic [31:0] exp_sboxw, exp_enc_nw, exp_key_nw;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected to be done", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic model_reset();
      m_owner  = OWN_NONE;
      m_last   = OWN_KEY;
      m_held   = 0;
      m_enc_v  = 1'b0;
      m_key_v  = 1'b0;
      m_enc_nw = 32'h0;
      m_key_nw = 32'h0;
   endtask

   function automatic owner_e next_owner(input logic er, input logic kr);
      logic   mine, other;
      owner_e rival;
      if (m_owner == OWN_NONE) begin
         if (er && kr) begin
`ifdef AES_SBOX_ARB_RR_EN
            return (m_last == OWN_ENC) ? OWN_KEY : OWN_ENC;
`else
            return OWN_KEY;
`endif
         end
         if (er) return OWN_ENC;
         if (kr) return OWN_KEY;
         return OWN_NONE;
      end
      mine  = (m_owner == OWN_ENC) ? er : kr;
      other = (m_owner == OWN_ENC) ? kr : er;
      rival = (m_owner == OWN_ENC) ? OWN_KEY : OWN_ENC;
      if (!mine) return other ? rival : OWN_NONE;
`ifdef AES_SBOX_ARB_RR_EN
      if (other && m_held >= MAX_BURST) return rival;
`endif
      return m_owner;
   endfunction

   // Applies one cycle of inputs, publishes this cycle's expectations, then steps the model past the edge.
   task automatic drive(input logic er, input logic kr, input logic [31:0] ew, input logic [31:0] kw);
      owner_e nxt;
      @(negedge clk);
      bus.enc_req  = er;
      bus.key_req  = kr;
      bus.enc_word = ew;
      bus.key_word = kw;
      #1;
      exp_enc_grant = (m_owner == OWN_ENC);
      exp_key_grant = (m_owner == OWN_KEY);
      exp_busy      = (m_owner != OWN_NONE);
      exp_sboxw     = (m_owner == OWN_ENC && er) ? ew :
                      (m_owner == OWN_KEY && kr) ? kw : 32'h0;
      exp_enc_valid = m_enc_v;
      exp_key_valid = m_key_v;
      exp_enc_nw    = m_enc_nw;
      exp_key_nw    = m_key_nw;

      m_enc_v = (m_owner == OWN_ENC) && er;
      m_key_v = (m_owner == OWN_KEY) && kr;
      if (m_enc_v) m_enc_nw = sub_word(ew);
      if (m_key_v) m_key_nw = sub_word(kw);
      nxt = next_owner(er, kr);
      if (nxt != m_owner) begin
         m_held = (nxt == OWN_NONE) ? 0 : 1;
         if (nxt != OWN_NONE) m_last = nxt;
      end else if (m_owner != OWN_NONE) begin
         m_held++;
      end
      m_owner = nxt;
   endtask

   task automatic test_reset();
      bus.enc_req  = 1'b0;
      bus.key_req  = 1'b0;
      bus.enc_word = $urandom;
      bus.key_word = $urandom;
      reset = 1'b0;
      #2 reset = 1'b1;
      #1;
      bus.enc_req = 1'b1;
      bus.key_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({bus.enc_grant, bus.key_grant, bus.enc_valid, bus.key_valid, bus.busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags[%0d]: got eg/kg/ev/kv/busy=%b, want 00000", i,
                     {bus.enc_grant, bus.key_grant, bus.enc_valid, bus.key_valid, bus.busy});
         end
         checks++;
         if (bus.sboxw !== 32'h0 || bus.enc_new_word !== 32'h0 || bus.key_new_word !== 32'h0) begin
            errors++;
            $display("FAIL reset_words[%0d]: got sboxw=%h enc_nw=%h key_nw=%h, want all 0", i,
                     bus.sboxw, bus.enc_new_word, bus.key_new_word);
         end
         @(posedge clk);
         #1;
      end
      bus.enc_req = 1'b0;
      bus.key_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_idle();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, $urandom, $urandom);
         checks++;
         if (bus.sboxw !== 32'h0 || bus.busy !== 1'b0 || bus.enc_valid !== 1'b0 || bus.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle[%0d]: got sboxw=%h busy=%b ev=%b kv=%b, want 0 0 0 0", i,
                     bus.sboxw, bus.busy, bus.enc_valid, bus.key_valid);
         end
      end
   endtask

   task automatic test_contention();
      logic want_enc;
      for (int i = 0; i < 4 * MAX_BURST + 2; i++) begin
         drive(1'b1, 1'b1, $urandom, $urandom);
         checks++;
         if (bus.enc_grant !== exp_enc_grant || bus.key_grant !== exp_key_grant) begin
            errors++;
            $display("FAIL contention_model[%0d]: got eg=%b kg=%b, want eg=%b kg=%b", i,
                     bus.enc_grant, bus.key_grant, exp_enc_grant, exp_key_grant);
         end
         if (i >= 1) begin
`ifdef AES_SBOX_ARB_RR_EN
            want_enc = (((i - 1) / MAX_BURST) % 2) == 0;
`else
            want_enc = 1'b0;
`endif
            checks++;
            if (bus.enc_grant !== want_enc || bus.key_grant !== !want_enc) begin
               errors++;
               $display("FAIL contention_pattern[%0d]: got eg=%b kg=%b, want eg=%b kg=%b", i,
                        bus.enc_grant, bus.key_grant, want_enc, !want_enc);
            end
         end
         checks++;
         if (bus.enc_valid === 1'b1 && bus.key_valid === 1'b1) begin
            errors++;
            $display("FAIL contention_valids[%0d]: got ev=1 kv=1, want at most one", i);
         end
      end
   endtask

   task automatic test_single_enc();
      logic [31:0] word;
      word = 32'h00112233;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 6; i++) begin
         drive(i < 5, 1'b0, word, $urandom);
         checks++;
         if (bus.enc_grant !== (i >= 1) || bus.enc_valid !== (i >= 2)) begin
            errors++;
            $display("FAIL single_enc_ctl[%0d]: got grant=%b valid=%b, want grant=%b valid=%b", i,
                     bus.enc_grant, bus.enc_valid, i >= 1, i >= 2);
         end
         checks++;
         if (bus.sboxw !== ((i >= 1 && i < 5) ? word : 32'h0)) begin
            errors++;
            $display("FAIL single_enc_sboxw[%0d]: got %h, want %h", i, bus.sboxw,
                     (i >= 1 && i < 5) ? word : 32'h0);
         end
         if (i >= 2) begin
            checks++;
            if (bus.enc_new_word !== sub_word(word)) begin
               errors++;
               $display("FAIL single_enc_word[%0d]: got %h, want %h", i, bus.enc_new_word, sub_word(word));
            end
         end
      end
   endtask

   task automatic test_owner_release();
      logic want_key;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, $urandom, $urandom);
      drive(1'b1, 1'b1, $urandom, $urandom);
      drive(1'b1, 1'b1, $urandom, $urandom);
      drive(1'b0, 1'b1, $urandom, $urandom);
      checks++;
      if (bus.enc_grant !== 1'b1) begin
         errors++;
         $display("FAIL release_owner: got enc_grant=%b, want 1 before release", bus.enc_grant);
      end
      for (int i = 0; i <= MAX_BURST; i++) begin
         drive(1'b1, 1'b1, $urandom, $urandom);
`ifdef AES_SBOX_ARB_RR_EN
         want_key = (i < MAX_BURST);
`else
         want_key = 1'b1;
`endif
         checks++;
         if (bus.key_grant !== want_key || bus.enc_grant !== !want_key) begin
            errors++;
            $display("FAIL release_handover[%0d]: got eg=%b kg=%b, want eg=%b kg=%b", i,
                     bus.enc_grant, bus.key_grant, !want_key, want_key);
         end
      end
   endtask

   task automatic test_mid_burst_reset();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b1, $urandom, $urandom);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, $urandom, $urandom);
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.enc_grant, bus.key_grant, bus.enc_valid, bus.key_valid, bus.busy} !== 5'b0 ||
          bus.sboxw !== 32'h0 || bus.enc_new_word !== 32'h0 || bus.key_new_word !== 32'h0) begin
         errors++;
         $display("FAIL midreset_outputs: got eg/kg/ev/kv/busy=%b sboxw=%h enc_nw=%h key_nw=%h, want all 0",
                  {bus.enc_grant, bus.key_grant, bus.enc_valid, bus.key_valid, bus.busy},
                  bus.sboxw, bus.enc_new_word, bus.key_new_word);
      end
      bus.enc_req = 1'b0;
      bus.key_req = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, $urandom, $urandom);
         checks++;
         if (bus.enc_valid !== 1'b0 || bus.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid[%0d]: got ev=%b kv=%b, want 0 0", i, bus.enc_valid, bus.key_valid);
         end
      end
      checks++;
`ifdef AES_SBOX_ARB_RR_EN
      if (bus.enc_grant !== 1'b1 || bus.key_grant !== 1'b0) begin
`else
      if (bus.enc_grant !== 1'b0 || bus.key_grant !== 1'b1) begin
`endif
         errors++;
         $display("FAIL midreset_first_grant: got eg=%b kg=%b", bus.enc_grant, bus.key_grant);
      end
   endtask

   task automatic test_random();
      int pe, pk;
      for (int i = 0; i < 400; i++) begin
         pe = (i < 100) ? 8 : (i < 200) ? 3 : (i < 300) ? 9 : 5;
         pk = (i < 100) ? 8 : (i < 200) ? 9 : (i < 300) ? 2 : 5;
         drive($urandom_range(0, 9) < pe, $urandom_range(0, 9) < pk, $urandom, $urandom);
         checks++;
         if (bus.enc_grant !== exp_enc_grant || bus.key_grant !== exp_key_grant || bus.busy !== exp_busy) begin
            errors++;
            $display("FAIL random_grant[%0d]: got eg=%b kg=%b busy=%b, want eg=%b kg=%b busy=%b", i,
                     bus.enc_grant, bus.key_grant, bus.busy, exp_enc_grant, exp_key_grant, exp_busy);
         end
         checks++;
         if (bus.sboxw !== exp_sboxw) begin
            errors++;
            $display("FAIL random_sboxw[%0d]: got %h, want %h", i, bus.sboxw, exp_sboxw);
         end
         checks++;
         if (bus.enc_valid !== exp_enc_valid || bus.key_valid !== exp_key_valid) begin
            errors++;
            $display("FAIL random_valid[%0d]: got ev=%b kv=%b, want ev=%b kv=%b", i,
                     bus.enc_valid, bus.key_valid, exp_enc_valid, exp_key_valid);
         end
         checks++;
         if (bus.enc_new_word !== exp_enc_nw || bus.key_new_word !== exp_key_nw) begin
            errors++;
            $display("FAIL random_words[%0d]: got enc=%h key=%h, want enc=%h key=%h", i,
                     bus.enc_new_word, bus.key_new_word, exp_enc_nw, exp_key_nw);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_idle();
      test_contention();
      test_single_enc();
      test_owner_release();
      test_mid_burst_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
